// File: rtl/mem_access_stage_if.sv
// Data-memory handshake between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: branch/jump resolution, variable-latency load/store handshake
// and the MEM/WB register, stalling upstream while an access is outstanding.
module mem_access_stage (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                in_alu_result,
  input  logic [31:0]                in_mem_write_data,
  input  logic                       in_mem_write,
  input  logic                       in_mem_reg,
  input  logic                       in_reg_write,
  input  logic [4:0]                 in_write_reg,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_branch,
  input  logic                       in_jal,
  input  logic                       in_jalr,
  input  logic                       in_zero,
  input  logic [31:0]                in_imm,
  input  logic [31:0]                in_PC,
  input  logic [31:0]                in_nextPC,
  mem_access_stage_if.master         dmem,
  output logic                       stall,
  output logic                       pc_src,
  output logic                       flush,
  output logic [31:0]                pc_target,
  output logic [31:0]                out_wb_data,
  output logic                       out_reg_write,
  output logic [4:0]                 out_write_reg,
  output logic                       out_misaligned
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  state_t      state_next;
  logic        req_raw;
  logic        mem_op;
  logic        is_half;
  logic        is_word;
  logic        bad_funct3;
  logic        misaligned;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        cond;
  logic        taken;
  logic [31:0] wb_next;

  assign off        = in_alu_result[1:0];
  assign mem_op     = in_mem_reg | in_mem_write;
  assign is_half    = (in_funct3[1:0] == 2'b01);
  assign is_word    = (in_funct3[1:0] == 2'b10);
  assign bad_funct3 = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
  assign misaligned = mem_op & ((is_half & off[0]) | (is_word & (off != 2'b00)) | bad_funct3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_raw    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          req_raw = 1'b1;
          if (!dmem.dmem_ack) state_next = WAIT;
        end
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dmem.dmem_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset must drop the request immediately, even though EX/MEM still presents the access.
  assign dmem.dmem_req   = req_raw & ~rst;
  assign dmem.dmem_we    = in_mem_write;
  assign dmem.dmem_addr  = {in_alu_result[31:2], 2'b00};
  assign dmem.dmem_be    = be;
  assign dmem.dmem_wdata = wdata;
  assign stall           = dmem.dmem_req & ~dmem.dmem_ack;

  always_comb begin
    be    = 4'b1111;
    wdata = in_mem_write_data;
    case (in_funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{in_mem_write_data[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{in_mem_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = dmem.dmem_rdata[7:0];
    case (off)
      2'b01:   load_byte = dmem.dmem_rdata[15:8];
      2'b10:   load_byte = dmem.dmem_rdata[23:16];
      2'b11:   load_byte = dmem.dmem_rdata[31:24];
      default: load_byte = dmem.dmem_rdata[7:0];
    endcase
    load_half = off[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (in_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b100:  load_data = {24'd0, load_byte};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = dmem.dmem_rdata;
    endcase
  end

  // blt/bltu rely on the ALU having produced slt/sltu, so "less than" shows up as !zero.
  always_comb begin
    cond = 1'b0;
    case (in_funct3)
      3'b000, 3'b101, 3'b111: cond = in_zero;
      3'b001, 3'b100, 3'b110: cond = ~in_zero;
      default:                cond = 1'b0;
    endcase
  end

  assign taken     = in_branch & cond;
  assign pc_src    = taken | in_jal | in_jalr;
  assign flush     = pc_src;
  assign pc_target = in_jalr ? (in_alu_result & 32'hFFFF_FFFE) : (in_PC + in_imm);

  assign wb_next = in_mem_reg ? load_data :
                   (in_jal | in_jalr) ? in_nextPC : in_alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wb_data    <= 32'd0;
      out_reg_write  <= 1'b0;
      out_write_reg  <= 5'd0;
      out_misaligned <= 1'b0;
    end else if (stall) begin
      out_reg_write  <= 1'b0;
      out_misaligned <= 1'b0;
    end else if (misaligned) begin
      out_reg_write  <= 1'b0;
      out_misaligned <= 1'b1;
    end else begin
      out_wb_data    <= wb_next;
      out_reg_write  <= in_reg_write;
      out_write_reg  <= in_write_reg;
      out_misaligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage plus hand-written
// sequences for multi-cycle memory latency and reset during WAIT.
module tb_mem_access_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        mw;
    logic        mr;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
  } stim_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] target;
    logic [31:0] wb;
    logic        rw;
    logic [4:0]  wr;
    logic        mis;
    logic        chk_mem;
    logic        chk_wb;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_write_data;
  logic        in_mem_write;
  logic        in_mem_reg;
  logic        in_reg_write;
  logic [4:0]  in_write_reg;
  logic [2:0]  in_funct3;
  logic        in_branch;
  logic        in_jal;
  logic        in_jalr;
  logic        in_zero;
  logic [31:0] in_imm;
  logic [31:0] in_PC;
  logic [31:0] in_nextPC;
  logic        stall;
  logic        pc_src;
  logic        flush;
  logic [31:0] pc_target;
  logic [31:0] out_wb_data;
  logic        out_reg_write;
  logic [4:0]  out_write_reg;
  logic        out_misaligned;

  int checks   = 0;
  int failures = 0;

  mem_access_stage_if dif ();

  mem_access_stage dut (
    .clk               (clk),
    .rst               (rst),
    .in_alu_result     (in_alu_result),
    .in_mem_write_data (in_mem_write_data),
    .in_mem_write      (in_mem_write),
    .in_mem_reg        (in_mem_reg),
    .in_reg_write      (in_reg_write),
    .in_write_reg      (in_write_reg),
    .in_funct3         (in_funct3),
    .in_branch         (in_branch),
    .in_jal            (in_jal),
    .in_jalr           (in_jalr),
    .in_zero           (in_zero),
    .in_imm            (in_imm),
    .in_PC             (in_PC),
    .in_nextPC         (in_nextPC),
    .dmem              (dif.master),
    .stall             (stall),
    .pc_src            (pc_src),
    .flush             (flush),
    .pc_target         (pc_target),
    .out_wb_data       (out_wb_data),
    .out_reg_write     (out_reg_write),
    .out_write_reg     (out_write_reg),
    .out_misaligned    (out_misaligned)
  );

  always #5 clk = ~clk;

  function automatic stim_t make_stim(
    input logic [31:0] alu, input logic [31:0] sdata, input logic mw, input logic mr,
    input logic rw, input logic [4:0] rd, input logic [2:0] f3, input logic br,
    input logic jal, input logic jalr, input logic zero, input logic [31:0] imm,
    input logic [31:0] pc, input logic [31:0] npc, input logic ack, input logic [31:0] rdata);
    stim_t s;
    s.alu = alu;  s.sdata = sdata; s.mw = mw;     s.mr = mr;
    s.rw = rw;    s.rd = rd;       s.f3 = f3;     s.br = br;
    s.jal = jal;  s.jalr = jalr;   s.zero = zero; s.imm = imm;
    s.pc = pc;    s.npc = npc;     s.ack = ack;   s.rdata = rdata;
    return s;
  endfunction

  function automatic exp_t make_exp(
    input logic req, input logic we, input logic [31:0] addr, input logic [3:0] be,
    input logic [31:0] wdata, input logic st, input logic src, input logic [31:0] target,
    input logic [31:0] wb, input logic rw, input logic [4:0] wr, input logic mis,
    input logic chk_mem, input logic chk_wb);
    exp_t e;
    e.req = req;   e.we = we;         e.addr = addr;     e.be = be;
    e.wdata = wdata; e.stall = st;    e.pc_src = src;    e.target = target;
    e.wb = wb;     e.rw = rw;         e.wr = wr;         e.mis = mis;
    e.chk_mem = chk_mem; e.chk_wb = chk_wb;
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    in_alu_result     = s.alu;
    in_mem_write_data = s.sdata;
    in_mem_write      = s.mw;
    in_mem_reg        = s.mr;
    in_reg_write      = s.rw;
    in_write_reg      = s.rd;
    in_funct3         = s.f3;
    in_branch         = s.br;
    in_jal            = s.jal;
    in_jalr           = s.jalr;
    in_zero           = s.zero;
    in_imm            = s.imm;
    in_PC             = s.pc;
    in_nextPC         = s.npc;
    dif.dmem_ack      = s.ack;
    dif.dmem_rdata    = s.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
    end
  endtask

  task automatic checkRegs(input string tag, input logic [31:0] wb, input logic rw,
                           input logic [4:0] wr, input logic mis);
    checkOutput({tag, ".wb_data"},    out_wb_data,           wb);
    checkOutput({tag, ".reg_write"},  {31'd0, out_reg_write}, {31'd0, rw});
    checkOutput({tag, ".write_reg"},  {27'd0, out_write_reg}, {27'd0, wr});
    checkOutput({tag, ".misaligned"}, {31'd0, out_misaligned}, {31'd0, mis});
  endtask

  stim_t idle_stim;
  stim_t s;
  vec_t  vecs[19];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_stim = make_stim(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
                          32'h0, 32'h0, 32'h4, 1'b0, 32'h0);

    //                          alu         sdata        mw    mr    rw    rd     f3      br    jal   jalr  z     imm           pc          npc         ack   rdata
    vecs[0]  = '{"lw_zero_wait", make_stim(32'h100, 32'h0,        1'b0, 1'b1, 1'b1, 5'd5, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'hDEADBEEF),
                 make_exp(1'b1, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0,    32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1)};
    vecs[1]  = '{"sh",           make_stim(32'h202, 32'h1234ABCD, 1'b1, 1'b0, 1'b0, 5'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'h0),
                 make_exp(1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD, 1'b0, 1'b0, 32'h0,    32'h202,      1'b0, 5'd0, 1'b0, 1'b1, 1'b1)};
    vecs[2]  = '{"sb",           make_stim(32'h101, 32'h000000A5, 1'b1, 1'b0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'h0),
                 make_exp(1'b1, 1'b1, 32'h100, 4'b0010, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,    32'h101,      1'b0, 5'd0, 1'b0, 1'b1, 1'b1)};
    vecs[3]  = '{"sw",           make_stim(32'h30C, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 5'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'h0),
                 make_exp(1'b1, 1'b1, 32'h30C, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,    32'h30C,      1'b0, 5'd0, 1'b0, 1'b1, 1'b1)};
    vecs[4]  = '{"lw_misaligned", make_stim(32'h101, 32'h0,       1'b0, 1'b1, 1'b1, 5'd7, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h100, 4'b1111, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 5'd0, 1'b1, 1'b1, 1'b0)};
    vecs[5]  = '{"bne_taken",    make_stim(32'h1,   32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8, 32'h40,  32'h44,  1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h38,   32'h1,        1'b0, 5'd0, 1'b0, 1'b0, 1'b1)};
    vecs[6]  = '{"beq_not_taken", make_stim(32'h1,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8, 32'h40,  32'h44,  1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h38,   32'h1,        1'b0, 5'd0, 1'b0, 1'b0, 1'b1)};
    vecs[7]  = '{"blt_taken",    make_stim(32'h1,   32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8, 32'h40,  32'h44,  1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h38,   32'h1,        1'b0, 5'd0, 1'b0, 1'b0, 1'b1)};
    vecs[8]  = '{"bgeu_taken",   make_stim(32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10,       32'h80,  32'h84,  1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h90,   32'h0,        1'b0, 5'd0, 1'b0, 1'b0, 1'b1)};
    vecs[9]  = '{"bge_not_taken", make_stim(32'h1,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10,       32'h80,  32'h84,  1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h90,   32'h1,        1'b0, 5'd0, 1'b0, 1'b0, 1'b1)};
    vecs[10] = '{"jalr",         make_stim(32'h1001, 32'h0,       1'b0, 1'b0, 1'b1, 5'd1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h20,  32'h24,  1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h1000, 32'h24,       1'b1, 5'd1, 1'b0, 1'b0, 1'b1)};
    vecs[11] = '{"jal",          make_stim(32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 5'd2, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20,       32'h100, 32'h104, 1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b1, 32'h120,  32'h104,      1'b1, 5'd2, 1'b0, 1'b0, 1'b1)};
    vecs[12] = '{"alu_stray_ack", make_stim(32'h55, 32'h0,        1'b0, 1'b0, 1'b1, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'hFFFFFFFF),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,    32'h55,       1'b1, 5'd3, 1'b0, 1'b0, 1'b1)};
    vecs[13] = '{"lhu_upper",    make_stim(32'h106, 32'h0,        1'b0, 1'b1, 1'b1, 5'd4, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'h80017FFF),
                 make_exp(1'b1, 1'b0, 32'h104, 4'b1100, 32'h0,        1'b0, 1'b0, 32'h0,    32'h00008001, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1)};
    vecs[14] = '{"lh_lower",     make_stim(32'h104, 32'h0,        1'b0, 1'b1, 1'b1, 5'd6, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'h12348002),
                 make_exp(1'b1, 1'b0, 32'h104, 4'b0011, 32'h0,        1'b0, 1'b0, 32'h0,    32'hFFFF8002, 1'b1, 5'd6, 1'b0, 1'b1, 1'b1)};
    vecs[15] = '{"lbu_lane2",    make_stim(32'h102, 32'h0,        1'b0, 1'b1, 1'b1, 5'd8, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b1, 32'h00AB0000),
                 make_exp(1'b1, 1'b0, 32'h100, 4'b0100, 32'h0,        1'b0, 1'b0, 32'h0,    32'h000000AB, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1)};
    vecs[16] = '{"write_x0",     make_stim(32'h77,  32'h0,        1'b0, 1'b0, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,    32'h77,       1'b1, 5'd0, 1'b0, 1'b0, 1'b1)};
    vecs[17] = '{"bad_funct3",   make_stim(32'h100, 32'h0,        1'b0, 1'b1, 1'b1, 5'd9, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 5'd0, 1'b1, 1'b0, 1'b0)};
    vecs[18] = '{"lh_misaligned", make_stim(32'h105, 32'h0,       1'b0, 1'b1, 1'b1, 5'd9, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,   32'h4,   1'b0, 32'h0),
                 make_exp(1'b0, 1'b0, 32'h0,   4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        1'b0, 5'd0, 1'b1, 1'b0, 1'b0)};

    rst = 1'b1;
    applyStimulus(idle_stim);
    @(negedge clk);
    #1;
    checkRegs("reset", 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("reset.dmem_req", {31'd0, dif.dmem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].s);
      #1;
      checkOutput({vecs[i].name, ".dmem_req"}, {31'd0, dif.dmem_req}, {31'd0, vecs[i].e.req});
      checkOutput({vecs[i].name, ".dmem_we"},  {31'd0, dif.dmem_we},  {31'd0, vecs[i].e.we});
      checkOutput({vecs[i].name, ".stall"},    {31'd0, stall},        {31'd0, vecs[i].e.stall});
      checkOutput({vecs[i].name, ".pc_src"},   {31'd0, pc_src},       {31'd0, vecs[i].e.pc_src});
      checkOutput({vecs[i].name, ".flush"},    {31'd0, flush},        {31'd0, vecs[i].e.pc_src});
      checkOutput({vecs[i].name, ".pc_target"}, pc_target,            vecs[i].e.target);
      if (vecs[i].e.chk_mem) begin
        checkOutput({vecs[i].name, ".dmem_addr"},  dif.dmem_addr,          vecs[i].e.addr);
        checkOutput({vecs[i].name, ".dmem_be"},    {28'd0, dif.dmem_be},   {28'd0, vecs[i].e.be});
        checkOutput({vecs[i].name, ".dmem_wdata"}, dif.dmem_wdata,         vecs[i].e.wdata);
      end
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, ".reg_write"},  {31'd0, out_reg_write},  {31'd0, vecs[i].e.rw});
      checkOutput({vecs[i].name, ".misaligned"}, {31'd0, out_misaligned}, {31'd0, vecs[i].e.mis});
      if (vecs[i].e.chk_wb) begin
        checkOutput({vecs[i].name, ".wb_data"},   out_wb_data,            vecs[i].e.wb);
        checkOutput({vecs[i].name, ".write_reg"}, {27'd0, out_write_reg}, {27'd0, vecs[i].e.wr});
      end
    end

    // Known MEM/WB contents so the hold behaviour during the stall below is observable.
    @(negedge clk);
    s = idle_stim;
    s.alu = 32'h99; s.rw = 1'b1; s.rd = 5'd10;
    applyStimulus(s);
    @(posedge clk);
    #1;
    checkRegs("pre_wait", 32'h99, 1'b1, 5'd10, 1'b0);

    // lb from 0x103 answered after three wait cycles.
    @(negedge clk);
    s = idle_stim;
    s.alu = 32'h103; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd9; s.f3 = 3'b000;
    applyStimulus(s);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("lb_wait%0d.stall", c),    {31'd0, stall},        32'd1);
      checkOutput($sformatf("lb_wait%0d.dmem_req", c), {31'd0, dif.dmem_req}, 32'd1);
      @(posedge clk);
      #1;
      checkRegs($sformatf("lb_wait%0d", c), 32'h99, 1'b0, 5'd10, 1'b0);
      @(negedge clk);
    end
    dif.dmem_ack   = 1'b1;
    dif.dmem_rdata = 32'h80FFFFFF;
    #1;
    checkOutput("lb_ack.stall",    {31'd0, stall},        32'd0);
    checkOutput("lb_ack.dmem_req", {31'd0, dif.dmem_req}, 32'd1);
    @(posedge clk);
    #1;
    checkRegs("lb_done", 32'hFFFFFF80, 1'b1, 5'd9, 1'b0);

    // Reset arriving while a load waits in WAIT.
    @(negedge clk);
    s = idle_stim;
    s.alu = 32'h200; s.mr = 1'b1; s.rw = 1'b1; s.rd = 5'd11; s.f3 = 3'b010;
    applyStimulus(s);
    #1;
    checkOutput("rst_wait.pre_req", {31'd0, dif.dmem_req}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("rst_wait.in_wait_stall", {31'd0, stall}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_wait.dmem_req", {31'd0, dif.dmem_req}, 32'd0);
    checkOutput("rst_wait.stall",    {31'd0, stall},        32'd0);
    checkRegs("rst_wait", 32'h0, 1'b0, 5'd0, 1'b0);
    applyStimulus(idle_stim);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst.dmem_req", {31'd0, dif.dmem_req}, 32'd0);
    checkOutput("post_rst.stall",    {31'd0, stall},        32'd0);
    @(posedge clk);
    #1;
    checkRegs("post_rst", 32'h0, 1'b0, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
